mem_wb_stage: RTL

// Memory-access stage plus MEM/WB pipeline register; consumes the EX/MEM register outputs.

---
 rtl/mem_wb_stage_if.sv | 35 +++
 rtl/mem_wb_stage.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the data memory.
// Latency: none, pure wiring bundle.
// Backpressure: memory stretches a request by withholding mem_ack; the stage holds req until ack or abort.
//
// Ports (via modports):
//   master (MEM stage): drives mem_req, mem_wr, mem_addr, mem_wdata; samples mem_ack, mem_rdata
//   slave  (memory)   : samples mem_req, mem_wr, mem_addr, mem_wdata; drives mem_ack, mem_rdata
interface mem_wb_stage_if #(
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_wr,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_wr,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB pipeline register; runs the data-memory req/ack handshake.
// Latency: 1 cycle EX/MEM -> MEM/WB with a 0-wait memory; each memory wait cycle adds one stall cycle.
// Backpressure: stall holds the upstream pipe while a request is outstanding; aborts after TIMEOUT waits.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   instruction..Mem_en EX/MEM register outputs (instruction, ALU result, store data, dest idx, controls)
//   mem                 data-memory bus (master side): req/wr/addr/wdata out, ack/rdata in
//   stall               hold PC, IF/ID, ID/EX, EX/MEM this cycle
//   *_o                 MEM/WB register outputs; err_o pulses one cycle when an access is aborted
module mem_wb_stage #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instruction,
    input  logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_two,
    input  logic [2:0]        write_sel,
    input  logic              Reg_write,
    input  logic              Mem_read,
    input  logic              Mem_write,
    input  logic              Mem_reg,
    input  logic              Mem_en,
    mem_wb_stage_if.master    mem,
    output logic              stall,
    output logic [15:0]       instruction_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [2:0]        write_sel_o,
    output logic              Reg_write_o,
    output logic              err_o
);

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       op;
    logic       req_c;
    logic       abort;
    logic       load_wb;

    assign op = Mem_en & (Mem_read | Mem_write);

    // Address/data/direction come straight from EX/MEM; the stall keeps them
    // stable for the whole WAIT period, so no local capture is needed.
    assign mem.mem_wr    = Mem_write;
    assign mem.mem_addr  = data_out;
    assign mem.mem_wdata = data_two;
    // Request must drop the instant reset asserts, even though an op may be presented.
    assign mem.mem_req   = req_c & rst;

    // A store never writes back memory data, even if Mem_read is also set.
    assign load_wb = Mem_reg & Mem_read & ~Mem_write;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_c   = 1'b0;
        stall   = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op) begin
                    req_c = 1'b1;
                    if (!mem.mem_ack) begin
                        stall   = 1'b1;
                        state_d = S_WAIT;
                        cnt_d   = 8'd1;
                    end
                end
            end
            S_WAIT: begin
                req_c = 1'b1;
                // Ack is tested first so it wins over a coincident timeout.
                if (mem.mem_ack) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q < TIMEOUT_C) begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MEM/WB register: advances when not stalled, otherwise injects a NOP bubble
    // while keeping the data/index fields to avoid needless toggling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instruction_o <= NOP_INSTR;
            wb_data_o     <= '0;
            write_sel_o   <= '0;
            Reg_write_o   <= 1'b0;
            err_o         <= 1'b0;
        end else if (!stall) begin
            instruction_o <= instruction;
            write_sel_o   <= write_sel;
            wb_data_o     <= load_wb ? mem.mem_rdata : data_out;
            Reg_write_o   <= Reg_write & ~abort;
            err_o         <= abort;
        end else begin
            instruction_o <= NOP_INSTR;
            Reg_write_o   <= 1'b0;
            err_o         <= 1'b0;
        end
    end

endmodule
